// File: rtl/kalman_pkg.sv
// rtl/kalman_pkg.sv - shared Q2.14 constants, FSM encoding and 2x2 matrix bundle
package kalman_pkg;

  localparam int Q_FRAC = 14;
  localparam int Q_ONE  = 16384;
  localparam int Q_MAX  = 32767;
  localparam int Q_MIN  = -32768;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL1 = 3'd1;
  localparam logic [2:0] S_MUL2 = 3'd2;
  localparam logic [2:0] S_ADDQ = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  typedef struct packed {
    logic signed [15:0] m11;
    logic signed [15:0] m12;
    logic signed [15:0] m21;
    logic signed [15:0] m22;
  } mat2_t;

endpackage

// File: rtl/mat2x2_mult.sv
// rtl/mat2x2_mult.sv - combinational 2x2 Q2.14 matrix product C = A*B
// Each product is floored by the Q2.14 shift; the pair sum wraps to 16 bits.
module mat2x2_mult
  import kalman_pkg::*;
(
  input  mat2_t a,
  input  mat2_t b,
  output mat2_t c
);

  function automatic logic signed [15:0] dot2(
    input logic signed [15:0] x0,
    input logic signed [15:0] y0,
    input logic signed [15:0] x1,
    input logic signed [15:0] y1
  );
    logic signed [31:0] p0;
    logic signed [31:0] p1;
    logic signed [31:0] s;
    p0 = 32'(x0) * 32'(y0);
    p1 = 32'(x1) * 32'(y1);
    p0 = p0 >>> Q_FRAC;
    p1 = p1 >>> Q_FRAC;
    s  = p0 + p1;
    return s[15:0];
  endfunction

  assign c.m11 = dot2(a.m11, b.m11, a.m12, b.m21);
  assign c.m12 = dot2(a.m11, b.m12, a.m12, b.m22);
  assign c.m21 = dot2(a.m21, b.m11, a.m22, b.m21);
  assign c.m22 = dot2(a.m21, b.m12, a.m22, b.m22);

endmodule

// File: rtl/sat_add16.sv
// rtl/sat_add16.sv - 16-bit signed add with optional clamp to the Q2.14 range
module sat_add16
  import kalman_pkg::*;
#(
  parameter int SAT_EN = 1
) (
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic signed [15:0] y
);

  logic [16:0] s;
  logic        ovf_hi;
  logic        ovf_lo;

  assign s      = {a[15], a} + {b[15], b};
  // Top two bits disagree only when the 17-bit sum left the 16-bit range.
  assign ovf_hi = (s[16:15] == 2'b01);
  assign ovf_lo = (s[16:15] == 2'b10);

  always_comb begin
    y = s[15:0];
    if (SAT_EN != 0) begin
      if (ovf_hi) y = 16'(Q_MAX);
      else if (ovf_lo) y = 16'(Q_MIN);
    end
  end

endmodule

// File: rtl/kalman_cov_predict_seq.sv
// rtl/kalman_cov_predict_seq.sv - Pn = F*P*F' + Q sequencer over one shared 2x2 multiplier
module kalman_cov_predict_seq
  import kalman_pkg::*;
#(
  parameter int SAT_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic signed [15:0] F11,
  input  logic signed [15:0] F12,
  input  logic signed [15:0] F21,
  input  logic signed [15:0] F22,
  input  logic signed [15:0] P11,
  input  logic signed [15:0] P12,
  input  logic signed [15:0] P21,
  input  logic signed [15:0] P22,
  input  logic signed [15:0] Q11,
  input  logic signed [15:0] Q12,
  input  logic signed [15:0] Q21,
  input  logic signed [15:0] Q22,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] Pn11,
  output logic signed [15:0] Pn12,
  output logic signed [15:0] Pn21,
  output logic signed [15:0] Pn22,
  output logic               busy
);

  logic [2:0] state;
  mat2_t      f_r, p_r, q_r, t_r, m_r, pn_r;
  mat2_t      a_op, b_op, prod;
  logic signed [15:0] s11, s12, s21, s22;

  // Second pass reuses the multiplier as T * F-transpose.
  always_comb begin
    a_op = f_r;
    b_op = p_r;
    if (state == S_MUL2) begin
      a_op     = t_r;
      b_op.m11 = f_r.m11;
      b_op.m12 = f_r.m21;
      b_op.m21 = f_r.m12;
      b_op.m22 = f_r.m22;
    end
  end

  mat2x2_mult u_mult (.a(a_op), .b(b_op), .c(prod));

  sat_add16 #(.SAT_EN(SAT_EN)) u_add11 (.a(m_r.m11), .b(q_r.m11), .y(s11));
  sat_add16 #(.SAT_EN(SAT_EN)) u_add12 (.a(m_r.m12), .b(q_r.m12), .y(s12));
  sat_add16 #(.SAT_EN(SAT_EN)) u_add21 (.a(m_r.m21), .b(q_r.m21), .y(s21));
  sat_add16 #(.SAT_EN(SAT_EN)) u_add22 (.a(m_r.m22), .b(q_r.m22), .y(s22));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      f_r   <= '0;
      p_r   <= '0;
      q_r   <= '0;
      t_r   <= '0;
      m_r   <= '0;
      pn_r  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_valid) begin
          f_r   <= '{m11: F11, m12: F12, m21: F21, m22: F22};
          p_r   <= '{m11: P11, m12: P12, m21: P21, m22: P22};
          q_r   <= '{m11: Q11, m12: Q12, m21: Q21, m22: Q22};
          state <= S_MUL1;
        end
        S_MUL1: begin
          t_r   <= prod;
          state <= S_MUL2;
        end
        S_MUL2: begin
          m_r   <= prod;
          state <= S_ADDQ;
        end
        S_ADDQ: begin
          pn_r  <= '{m11: s11, m12: s12, m21: s21, m22: s22};
          state <= S_DONE;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign start_ready = (state == S_IDLE);
  assign out_valid   = (state == S_DONE);
  assign busy        = (state != S_IDLE);

  assign Pn11 = pn_r.m11;
  assign Pn12 = pn_r.m12;
  assign Pn21 = pn_r.m21;
  assign Pn22 = pn_r.m22;

endmodule

// File: tb/tb_kalman_cov_predict_seq.sv
// tb/tb_kalman_cov_predict_seq.sv - directed bench for the covariance-predict sequencer
// Two instances (saturating and wrapping) share stimulus; a matrix-level model predicts results.
module tb_kalman_cov_predict_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_valid = 1'b0;
  logic out_ready = 1'b0;
  int   fv[4];
  int   pv[4];
  int   qv[4];

  logic sr1, ov1, busy1, sr0, ov0, busy0;
  logic signed [15:0] o1[4];
  logic signed [15:0] o0[4];

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int hs_count = 0;
  bit prev_v = 1'b0;

  typedef struct {
    int e1[4];
    int e0[4];
    int acc;
  } exp_t;
  exp_t eq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  kalman_cov_predict_seq #(.SAT_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr1),
    .F11(fv[0][15:0]), .F12(fv[1][15:0]), .F21(fv[2][15:0]), .F22(fv[3][15:0]),
    .P11(pv[0][15:0]), .P12(pv[1][15:0]), .P21(pv[2][15:0]), .P22(pv[3][15:0]),
    .Q11(qv[0][15:0]), .Q12(qv[1][15:0]), .Q21(qv[2][15:0]), .Q22(qv[3][15:0]),
    .out_valid(ov1), .out_ready(out_ready),
    .Pn11(o1[0]), .Pn12(o1[1]), .Pn21(o1[2]), .Pn22(o1[3]), .busy(busy1)
  );

  kalman_cov_predict_seq #(.SAT_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr0),
    .F11(fv[0][15:0]), .F12(fv[1][15:0]), .F21(fv[2][15:0]), .F22(fv[3][15:0]),
    .P11(pv[0][15:0]), .P12(pv[1][15:0]), .P21(pv[2][15:0]), .P22(pv[3][15:0]),
    .Q11(qv[0][15:0]), .Q12(qv[1][15:0]), .Q21(qv[2][15:0]), .Q22(qv[3][15:0]),
    .out_valid(ov0), .out_ready(out_ready),
    .Pn11(o0[0]), .Pn12(o0[1]), .Pn21(o0[2]), .Pn22(o0[3]), .busy(busy0)
  );

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at cycle %0d", nm, got, want, cycle);
    end
  endtask

  function automatic longint floor_q(input longint x);
    longint q;
    q = x / 16384;
    if (x < 0 && q * 16384 != x) q = q - 1;
    return q;
  endfunction

  function automatic int wrap16(input longint x);
    longint y;
    y = x % 65536;
    if (y < 0) y = y + 65536;
    if (y >= 32768) y = y - 65536;
    return int'(y);
  endfunction

  task automatic mm(input int a[4], input int b[4], output int c[4]);
    c[0] = wrap16(floor_q(longint'(a[0]) * b[0]) + floor_q(longint'(a[1]) * b[2]));
    c[1] = wrap16(floor_q(longint'(a[0]) * b[1]) + floor_q(longint'(a[1]) * b[3]));
    c[2] = wrap16(floor_q(longint'(a[2]) * b[0]) + floor_q(longint'(a[3]) * b[2]));
    c[3] = wrap16(floor_q(longint'(a[2]) * b[1]) + floor_q(longint'(a[3]) * b[3]));
  endtask

  task automatic model(output int e1[4], output int e0[4]);
    int ft[4];
    int t[4];
    int m[4];
    longint s;
    ft = '{fv[0], fv[2], fv[1], fv[3]};
    mm(fv, pv, t);
    mm(t, ft, m);
    for (int i = 0; i < 4; i++) begin
      s = longint'(m[i]) + qv[i];
      e0[i] = wrap16(s);
      e1[i] = (s > 32767) ? 32767 : (s < -32768) ? -32768 : int'(s);
    end
  endtask

  // Compare process: records accepts, then checks every cycle the result is presented.
  always @(negedge clk) begin : monitor
    exp_t e;
    int a1[4];
    int a0[4];
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (start_valid && sr1) begin
        model(a1, a0);
        e.e1 = a1;
        e.e0 = a0;
        e.acc = cycle + 1;
        eq.push_back(e);
      end
      if (ov1) begin
        if (eq.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          if (!prev_v) chk("latency", cycle - eq[0].acc, 3);
          for (int i = 0; i < 4; i++) begin
            chk("model_pn_sat", int'(o1[i]), eq[0].e1[i]);
            chk("model_pn_wrap", int'(o0[i]), eq[0].e0[i]);
          end
          chk("done_start_ready", int'(sr1), 0);
          chk("done_busy", int'(busy1), 1);
          chk("lockstep_valid", int'(ov0), 1);
          if (out_ready) begin
            hs_count++;
            eq.delete(0);
          end
        end
      end
      prev_v = ov1 && !out_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int f0, f1, f2, f3, p0, p1, p2, p3, q0, q1, q2, q3);
    fv = '{f0, f1, f2, f3};
    pv = '{p0, p1, p2, p3};
    qv = '{q0, q1, q2, q3};
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!sr1 && n < 20) begin
      tick();
      n++;
    end
    if (!sr1) chk("timeout_start_ready", 0, 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!ov1 && n < 20) begin
      tick();
      n++;
    end
    if (!ov1) chk("timeout_out_valid", 0, 1);
  endtask

  task automatic check_lit(input string nm, input int s0, s1, s2, s3, w0, w1, w2, w3);
    chk({nm, "_sat11"}, int'(o1[0]), s0);
    chk({nm, "_sat12"}, int'(o1[1]), s1);
    chk({nm, "_sat21"}, int'(o1[2]), s2);
    chk({nm, "_sat22"}, int'(o1[3]), s3);
    chk({nm, "_wrap11"}, int'(o0[0]), w0);
    chk({nm, "_wrap12"}, int'(o0[1]), w1);
    chk({nm, "_wrap21"}, int'(o0[2]), w2);
    chk({nm, "_wrap22"}, int'(o0[3]), w3);
  endtask

  task automatic run_txn(input string nm, input int s0, s1, s2, s3, w0, w1, w2, w3);
    wait_ready();
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    wait_valid();
    check_lit(nm, s0, s1, s2, s3, w0, w1, w2, w3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin : stim
    int hs0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("reset_pn_sat", int'(o1[i]), 0);
      chk("reset_pn_wrap", int'(o0[i]), 0);
    end
    chk("reset_out_valid", int'(ov1 | ov0), 0);
    chk("reset_busy", int'(busy1 | busy0), 0);
    chk("reset_start_ready", int'(sr1 & sr0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    set_in(16384, 0, 0, 16384, 16384, 0, 0, 8192, 0, 0, 0, 0);
    run_txn("identity", 16384, 0, 0, 8192, 16384, 0, 0, 8192);

    set_in(16384, 16384, 0, 16384, 8192, 0, 0, 8192, 164, 0, 0, 164);
    run_txn("const_vel", 16548, 8192, 8192, 8356, 16548, 8192, 8192, 8356);

    set_in(16384, 0, 0, 16384, 30000, 0, 0, -30000, 5000, 0, 0, -5000);
    run_txn("sat_wrap", 32767, 0, 0, -32768, -30536, 0, 0, 30536);

    set_in(8192, 0, 0, 8192, -1, 0, 0, 1, 0, 0, 0, 0);
    run_txn("floor_shift", -1, 0, 0, 0, -1, 0, 0, 0);

    // Backpressure: consumer stalls while a new request is already waiting.
    set_in(16384, 16384, 0, 16384, 8192, 0, 0, 8192, 164, 0, 0, 164);
    wait_ready();
    start_valid = 1'b1;
    tick();
    wait_valid();
    hs0 = hs_count;
    for (int k = 0; k < 5; k++) begin
      chk("bp_start_ready", int'(sr1), 0);
      chk("bp_out_valid", int'(ov1), 1);
      chk("bp_pn11", int'(o1[0]), 16548);
      chk("bp_pn22", int'(o1[3]), 8356);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_one_handshake", hs_count - hs0, 1);
    chk("bp_idle_after_hs", int'(sr1), 1);
    chk("bp_valid_dropped", int'(ov1), 0);
    tick();
    chk("bp_next_accept_busy", int'(busy1), 1);
    chk("bp_next_accept_ready", int'(sr1), 0);
    start_valid = 1'b0;
    wait_valid();
    check_lit("bp_second", 16548, 8192, 8192, 8356, 16548, 8192, 8192, 8356);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_two_handshakes", hs_count - hs0, 2);

    // Reset lands while the second multiply pass is in progress.
    set_in(16384, 0, 0, 16384, 16384, 0, 0, 8192, 0, 0, 0, 0);
    wait_ready();
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    eq.delete();
    for (int i = 0; i < 4; i++) begin
      chk("midrst_pn_sat", int'(o1[i]), 0);
      chk("midrst_pn_wrap", int'(o0[i]), 0);
    end
    chk("midrst_out_valid", int'(ov1 | ov0), 0);
    chk("midrst_busy", int'(busy1 | busy0), 0);
    chk("midrst_start_ready", int'(sr1 & sr0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_txn("post_reset", 16384, 0, 0, 8192, 16384, 0, 0, 8192);

    tick();
    chk("queue_drained", eq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
